multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the multi-cycle MIPS datapath: shared memory, IR, register file, ALU, PC.
//  Decodes opcode in DECODE, then steps the instruction through its phases.
//  Stalls on a memory ready handshake; replaces the single-cycle decoder when the datapath goes multi-cycle.
// PARAMETERS
//  STATE_W     4  width of state register / debug port
//  TRAP_ILLEGAL 1  1: unknown opcode goes through ILLEGAL state; 0: unknown opcode returns to FETCH silently
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  instr[31:26] from IR, valid from DECODE onward
//  mem_ready      in   1  memory completes current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  iord           out  1  mem addr: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load IR from memory data
//  mem_to_reg     out  1  RF write data: 0=ALUOut, 1=MDR
//  reg_dst        out  1  RF dest: 0=rt, 1=rd
//  reg_write      out  1  RF write enable
//  alu_src_a      out  1  0=PC, 1=A
//  alu_src_b      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op         out  2  00=add, 01=sub, 10=funct field
//  pc_source      out  2  00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1  one-cycle pulse on unknown opcode
//  state          out  STATE_W  current state, debug
// BEHAVIOUR
//  Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010.
//  Reset: state=RESET asynchronously; all outputs 0 while in RESET. First clk after rst_n high -> FETCH.
//  Outputs: decoded purely from state, plus mem_ready where noted. All unlisted outputs are 0 in each state.
//  States, asserted outputs -> next state:
//   FETCH   : mem_read, alu_src_b=01; ir_write=pc_write=mem_ready. Next: DECODE if mem_ready, else FETCH.
//   DECODE  : alu_src_b=11 (branch target into ALUOut). Next by opcode:
//             LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, J->JUMP, other->ILLEGAL (TRAP_ILLEGAL=0: FETCH).
//   MEMADR  : alu_src_a=1, alu_src_b=10. Next: LW->MEMRD, SW->MEMWR.
//   MEMRD   : mem_read, iord. Next: MEMWB when mem_ready, else hold.
//   MEMWB   : reg_write, mem_to_reg, reg_dst=0. Next: FETCH.
//   MEMWR   : mem_write, iord. Next: FETCH when mem_ready, else hold.
//   EXEC    : alu_src_a=1, alu_op=10. Next: ALUWB.
//   ALUWB   : reg_write, reg_dst=1. Next: FETCH.
//   BRANCH  : alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01. Next: FETCH.
//   JUMP    : pc_write, pc_source=10. Next: FETCH.
//   ILLEGAL : illegal_op. Next: FETCH. PC is already advanced, so the instruction is skipped.
//  Cycle counts with mem_ready always 1: R=4, LW=5, SW=4, BEQ=3, J=3.
//  Each wait cycle adds exactly one cycle to the count.
//  Memory request: mem_read/mem_write hold steady while waiting; they drop the cycle after mem_ready.
//  Stall rules:
//   - ir_write/pc_write in FETCH fire only in the mem_ready cycle (exactly once per instruction).
//   - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  Opcode sampling: opcode is sampled only in DECODE and MEMADR. IR is stable there because ir_write=0.
//  Reset mid-instruction: immediate return to RESET. No partial write may complete after rst_n falls.
//  Unused state encodings: -> FETCH next cycle, outputs 0.
// STRUCTURE
//  Shared header ctrl_defs.vh, guarded by `ifndef:
//   - opcode constants, state encodings, ALU src/op/pc_source codes.
//   - to be shared with Control and the ALU control decoder.
//  Optional sub-module mc_output_decode: combinational state -> control word.
//  Next-state logic and state register stay in multicycle_control.
// TESTING
//  1. rst_n=0 then release, mem_ready=1 -> state RESET->FETCH; all outputs 0 during reset.
//  2. R (000000), mem_ready=1 -> FETCH,DECODE,EXEC,ALUWB.
//     Checks: reg_write=1, reg_dst=1 in cycle 4; one ir_write; one pc_write.
//  3. LW (100011), mem_ready low 2 cycles in MEMRD.
//     Checks: MEMRD held 3 cycles with mem_read=iord=1; MEMWB reg_write=1, mem_to_reg=1; total 7 cycles.
//  4. SW (101011), then BEQ (000100).
//     Checks: mem_write only in MEMWR with iord=1, no reg_write; BRANCH has pc_write_cond=1, alu_op=01, pc_source=01.
//  5. opcode 111111, TRAP_ILLEGAL=1 -> illegal_op=1 for 1 cycle in state 4; no reg/mem write; back to FETCH.
//  6. rst_n dropped during MEMWR with mem_ready=0 -> mem_write=0 immediately (async); restart at FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, state encodings, datapath select codes and the control word shared by the multi-cycle controller.
package multicycle_control_pkg;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BR    = 2'b11;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_OUT    = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    RESET   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    ILLEGAL = 4'd4,
    MEMRD   = 4'd5,
    MEMWB   = 4'd6,
    MEMWR   = 4'd7,
    EXEC    = 4'd8,
    ALUWB   = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11
  } state_e;
  // fetch marks the cycle whose ir_write/pc_write are gated by mem_ready
  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bus between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// multicycle_control_output_decode: combinational state -> control word; unused encodings and RESET give all zeros.
module multicycle_control_output_decode
  import multicycle_control_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.fetch     = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
      end
      DECODE: ctrl.alu_src_b = SRCB_BR;
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_OUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      ILLEGAL: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multi-cycle MIPS datapath, stalling on the memory ready handshake.
// The control word is decoded from the next state and registered, so outputs are glitch-free and clear asynchronously on reset.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus,
  output logic [STATE_W-1:0]  state
);
  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default:      state_d = (TRAP_ILLEGAL != 0) ? ILLEGAL : FETCH;
        endcase
      MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end
  multicycle_control_output_decode u_decode (
    .state (state_d),
    .ctrl  (ctrl_d)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end
  // ir_write/pc_write fire once per instruction, only in the FETCH cycle memory completes
  assign bus.ir_write      = ctrl_q.fetch & bus.mem_ready;
  assign bus.pc_write      = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready);
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.iord          = ctrl_q.iord;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.illegal_op    = ctrl_q.illegal_op;
  assign state             = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-instruction checks of state sequence and control outputs of multicycle_control.
module tb_multicycle_control;
  import multicycle_control_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] st;
  logic [16:0] o;
  int n_tests = 0;
  int n_fail = 0;
  multicycle_control_if bus();
  multicycle_control #(.STATE_W(4), .TRAP_ILLEGAL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (st)
  );
  always #5 clk = ~clk;
  // {pc_write,pc_write_cond,iord,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source,illegal_op}
  assign o = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
              bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.pc_source, bus.illegal_op};
  localparam logic [16:0] W_F_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] W_F_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] W_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] W_MADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] W_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] W_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] W_EXE    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] W_AWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] W_BR     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] W_JMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] W_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_R;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (st !== 4'(RESET)) begin n_fail++; $display("FAIL reset_state got %0d want %0d", st, RESET); end
    n_tests++;
    if (o !== 17'd0) begin n_fail++; $display("FAIL reset_outs got %b want 0", o); end
    #2 rst_n = 1'b1;
    nxt();
    n_tests++;
    if (st !== 4'(FETCH)) begin n_fail++; $display("FAIL reset_release got %0d want %0d", st, FETCH); end
  endtask
  task automatic test_r;
    state_e es[4] = '{FETCH, DECODE, EXEC, ALUWB};
    logic [16:0] ew[4] = '{W_F_RDY, W_DEC, W_EXE, W_AWB};
    int irw = 0, pcw = 0;
    bus.opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b1;
      #1;
      irw += int'(bus.ir_write);
      pcw += int'(bus.pc_write);
      n_tests++;
      if (st !== es[i] || o !== ew[i]) begin n_fail++; $display("FAIL r_cycle%0d got st=%0d o=%b want st=%0d o=%b", i + 1, st, o, es[i], ew[i]); end
      nxt();
    end
    n_tests++;
    if (irw != 1 || pcw != 1) begin n_fail++; $display("FAIL r_writes got ir=%0d pc=%0d want 1 1", irw, pcw); end
    n_tests++;
    if (st !== 4'(FETCH)) begin n_fail++; $display("FAIL r_end got %0d want %0d", st, FETCH); end
  endtask
  task automatic test_lw_stall;
    state_e es[7] = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMWB};
    logic [16:0] ew[7] = '{W_F_RDY, W_DEC, W_MADR, W_MRD, W_MRD, W_MRD, W_MWB};
    logic mr[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = OP_LW;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #1;
      n_tests++;
      if (st !== es[i] || o !== ew[i]) begin n_fail++; $display("FAIL lw_cycle%0d got st=%0d o=%b want st=%0d o=%b", i + 1, st, o, es[i], ew[i]); end
      nxt();
    end
    n_tests++;
    if (st !== 4'(FETCH)) begin n_fail++; $display("FAIL lw_total got %0d want %0d", st, FETCH); end
  endtask
  task automatic test_sw_fetch_stall;
    state_e es[6] = '{FETCH, FETCH, DECODE, MEMADR, MEMWR, MEMWR};
    logic [16:0] ew[6] = '{W_F_WAIT, W_F_RDY, W_DEC, W_MADR, W_MWR, W_MWR};
    logic mr[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int irw = 0;
    bus.opcode = OP_SW;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = mr[i];
      #1;
      irw += int'(bus.ir_write);
      n_tests++;
      if (st !== es[i] || o !== ew[i]) begin n_fail++; $display("FAIL sw_cycle%0d got st=%0d o=%b want st=%0d o=%b", i + 1, st, o, es[i], ew[i]); end
      nxt();
    end
    n_tests++;
    if (irw != 1) begin n_fail++; $display("FAIL sw_ir_write got %0d want 1", irw); end
    n_tests++;
    if (st !== 4'(FETCH) || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL sw_drop got st=%0d mw=%b want %0d 0", st, bus.mem_write, FETCH); end
  endtask
  task automatic test_back_to_back;
    logic [5:0] ops[3] = '{OP_BEQ, OP_J, 6'b111111};
    state_e last[3] = '{BRANCH, JUMP, ILLEGAL};
    logic [16:0] lw[3] = '{W_BR, W_JMP, W_ILL};
    for (int k = 0; k < 3; k++) begin
      bus.opcode = ops[k];
      bus.mem_ready = 1'b1;
      #1;
      n_tests++;
      if (st !== 4'(FETCH) || o !== W_F_RDY) begin n_fail++; $display("FAIL b2b%0d_fetch got st=%0d o=%b", k, st, o); end
      nxt();
      n_tests++;
      if (st !== 4'(DECODE) || o !== W_DEC) begin n_fail++; $display("FAIL b2b%0d_decode got st=%0d o=%b", k, st, o); end
      nxt();
      n_tests++;
      if (st !== last[k] || o !== lw[k]) begin n_fail++; $display("FAIL b2b%0d_exec got st=%0d o=%b want st=%0d o=%b", k, st, o, last[k], lw[k]); end
      nxt();
    end
    n_tests++;
    if (st !== 4'(FETCH) || bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got st=%0d ill=%b want %0d 0", st, bus.illegal_op, FETCH); end
  endtask
  task automatic test_reset_mid_write;
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b1;
    repeat (3) nxt();
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if (st !== 4'(MEMWR) || bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_pre got st=%0d mw=%b want %0d 1", st, bus.mem_write, MEMWR); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (st !== 4'(RESET) || o !== 17'd0) begin n_fail++; $display("FAIL rst_async got st=%0d o=%b want 0 0", st, o); end
    bus.mem_ready = 1'b1;
    nxt();
    #1 rst_n = 1'b1;
    nxt();
    n_tests++;
    if (st !== 4'(FETCH) || o !== W_F_RDY) begin n_fail++; $display("FAIL rst_restart got st=%0d o=%b want %0d %b", st, o, FETCH, W_F_RDY); end
  endtask
  initial begin
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_r();
    test_lw_stall();
    test_sw_fetch_stall();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
